mux_2to1_reg: RTL and testbench
===============================

Name: mux_2to1_reg

Overview:
- Parameterised 2:1 data selector with a combinational output and a registered output stage.
- Selects input word i0 when s=0 and i1 when s=1. The selected word is captured into an output register when in_valid is high.
- Used as a generic steering element in datapaths that need a same-cycle select and a one-cycle-registered select with valid tracking.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs (legal range 1..64).
- RESET_VAL, 0, value loaded into y on reset (WIDTH bits, zero-extended or truncated to WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i0  input  WIDTH  data word selected when s=0.
- i1  input  WIDTH  data word selected when s=1.
- s  input  1  select: 0 -> i0, 1 -> i1.
- in_valid  input  1  qualifies i0/i1/s for capture on the next rising clk.
- y_comb  output  WIDTH  combinational select result, s ? i1 : i0.
- y  output  WIDTH  registered select result.
- sel_q  output  1  value of s captured with the last accepted word.
- out_valid  output  1  high for exactly the cycle after each accepted word.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- y_comb has zero latency. It is purely combinational from i0, i1 and s, and is independent of clk, rst and in_valid.
- s=0 -> y_comb = i0; s=1 -> y_comb = i1. No other encodings exist.
- Reset (rst=1, asserted at any time, including mid-transfer): immediately forces y=RESET_VAL, sel_q=0 and out_valid=0. These values are held while rst is high. y_comb is unaffected.
- After rst deasserts, the first capture occurs on the first rising clk edge with in_valid=1.
- Rising clk edge with in_valid=1: y <= y_comb, sel_q <= s, out_valid <= 1. Latency from input to y is 1 cycle.
- Rising clk edge with in_valid=0: y and sel_q hold their values; out_valid <= 0.
- Back-to-back in_valid: every cycle is accepted. There is no backpressure and no stall, so out_valid stays high continuously.
- Changes to s or data between clock edges affect only y_comb. y changes only at a clock edge.
- The output is full-width: no truncation, sign extension or arithmetic is performed.
- X/Z on s: behaviour is undefined and not checked. The bench must drive s to a known value.

Decomposition:
- Shared package mux_pkg:
  - localparam SEL_I0 = 1'b0, SEL_I1 = 1'b1.
  - A function mux2(a, b, sel) returning the selected word. It is used by both the RTL and the bench reference model.
- One natural sub-module: mux2_comb, a pure combinational WIDTH-bit 2:1 cell. It is instantiated once to drive y_comb.
- The top level adds the capture register, sel_q and out_valid.

Test Plan:
- Reset: assert rst mid-cycle with y=1, out_valid=1 -> y=RESET_VAL (0), sel_q=0 and out_valid=0 immediately, before any clk edge.
- Exhaustive at WIDTH=1: all 8 combinations of {i1,i0,s}.
  - Examples: i1=1, i0=0, s=0 -> y_comb=0; i1=1, i0=0, s=1 -> y_comb=1.
  - With in_valid=1, y equals the same value one cycle later, and out_valid=1.
- Hold: WIDTH=8, accept i0=8'hA5 with s=0, then drive in_valid=0 and change i0 to 8'h3C -> y stays 8'hA5, sel_q=0, out_valid=0, y_comb=8'h3C.
- Streaming: WIDTH=8, in_valid=1 for 4 cycles with s=0,1,0,1, i0=8'h11, i1=8'h22 -> y sequence 11,22,11,22, each lagging by 1 cycle; out_valid high for 4 consecutive cycles.
- Random: 5+ random {i0, i1, s, in_valid} vectors at 10-time-unit spacing -> y_comb and y match the mux_pkg::mux2 reference model every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select encodings and word-select helper for mux_2to1_reg
package mux_pkg;

   localparam int MAX_WIDTH = 64;

   localparam logic SEL_I0 = 1'b0;
   localparam logic SEL_I1 = 1'b1;

   typedef logic [MAX_WIDTH-1:0] word_t;

   // Callers zero-extend narrower words to word_t and cast the result back down.
   function automatic word_t mux2(input word_t a, input word_t b, input logic sel);
      return (sel == SEL_I1) ? b : a;
   endfunction

endpackage

// File: rtl/mux2_comb.sv
// rtl/mux2_comb.sv - combinational WIDTH-bit 2:1 select cell
// Ports: a (selected when sel=0), b (selected when sel=1), sel, y = sel ? b : a.
module mux2_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = WIDTH'(mux2(word_t'(a), word_t'(b), sel));

endmodule

// File: rtl/mux_2to1_reg.sv
// rtl/mux_2to1_reg.sv - 2:1 selector with combinational and registered outputs
// Ports: clk, rst (async, active-high); i0/i1 data words; s select; in_valid
// qualifies capture; y_comb same-cycle select; y registered select; sel_q
// select captured with y; out_valid high the cycle after each accepted word.
module mux_2to1_reg
   import mux_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             s,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y_comb,
   output logic [WIDTH-1:0] y,
   output logic             sel_q,
   output logic             out_valid
);

   mux2_comb #(
      .WIDTH (WIDTH)
   ) u_mux2_comb (
      .a   (i0),
      .b   (i1),
      .sel (s),
      .y   (y_comb)
   );

   // No backpressure: every in_valid cycle is captured, so out_valid simply
   // follows in_valid one cycle later while y/sel_q hold on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y         <= RESET_VAL;
         sel_q     <= SEL_I0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y     <= y_comb;
            sel_q <= s;
         end
      end
   end

endmodule

// File: tb/tb_mux_2to1_reg.sv
// tb/tb_mux_2to1_reg.sv - self-checking bench for mux_2to1_reg at WIDTH 1 and 8
module tb_mux_2to1_reg;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       a_i0 = 1'b0, a_i1 = 1'b0, a_s = 1'b0, a_iv = 1'b0;
   logic       a_yc, a_y, a_sq, a_ov;
   logic [7:0] b_i0 = '0, b_i1 = '0;
   logic       b_s = 1'b0, b_iv = 1'b0;
   logic [7:0] b_yc, b_y;
   logic       b_sq, b_ov;

   logic       e_ay, e_asq, e_aov;
   logic [7:0] e_by;
   logic       e_bsq, e_bov;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_2to1_reg #(.WIDTH(1)) dut_a (
      .clk(clk), .rst(rst), .i0(a_i0), .i1(a_i1), .s(a_s), .in_valid(a_iv),
      .y_comb(a_yc), .y(a_y), .sel_q(a_sq), .out_valid(a_ov)
   );

   mux_2to1_reg #(.WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .i0(b_i0), .i1(b_i1), .s(b_s), .in_valid(b_iv),
      .y_comb(b_yc), .y(b_y), .sel_q(b_sq), .out_valid(b_ov)
   );

   // Reference: what both registers should hold after the coming rising edge.
   task automatic model_edge();
      if (rst) begin
         e_ay = 1'b0; e_asq = 1'b0; e_aov = 1'b0;
         e_by = 8'h00; e_bsq = 1'b0; e_bov = 1'b0;
      end else begin
         e_aov = a_iv;
         e_bov = b_iv;
         if (a_iv) begin
            e_ay  = 1'(mux2(word_t'(a_i0), word_t'(a_i1), a_s));
            e_asq = a_s;
         end
         if (b_iv) begin
            e_by  = 8'(mux2(word_t'(b_i0), word_t'(b_i1), b_s));
            e_bsq = b_s;
         end
      end
   endtask

   task automatic clock_and_model();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      model_edge();
      n_checks++; if (a_y !== 1'b0)  begin n_fail++; $display("FAIL rst_init_a_y got=%0h exp=0", a_y); end
      n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_init_a_ov got=%0h exp=0", a_ov); end
      n_checks++; if (b_y !== 8'h00) begin n_fail++; $display("FAIL rst_init_b_y got=%0h exp=00", b_y); end
      n_checks++; if (b_sq !== 1'b0) begin n_fail++; $display("FAIL rst_init_b_sq got=%0h exp=0", b_sq); end
      @(negedge clk);
      rst = 1'b0;
      a_i0 = 1'b0; a_i1 = 1'b1; a_s = SEL_I1; a_iv = 1'b1;
      clock_and_model();
      n_checks++; if (a_y !== 1'b1)  begin n_fail++; $display("FAIL rst_pre_a_y got=%0h exp=1", a_y); end
      n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL rst_pre_a_ov got=%0h exp=1", a_ov); end
      // Mid-cycle, before any further edge.
      #2 rst = 1'b1;
      #1;
      n_checks++; if (a_y !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_a_y got=%0h exp=0", a_y); end
      n_checks++; if (a_sq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_a_sq got=%0h exp=0", a_sq); end
      n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_mid_a_ov got=%0h exp=0", a_ov); end
      n_checks++; if (a_yc !== 1'b1) begin n_fail++; $display("FAIL rst_mid_a_ycomb got=%0h exp=1", a_yc); end
      // Held through an edge with in_valid still high.
      clock_and_model();
      n_checks++; if (a_y !== e_ay || a_ov !== e_aov) begin n_fail++; $display("FAIL rst_hold_a got y=%0h ov=%0h exp y=%0h ov=%0h", a_y, a_ov, e_ay, e_aov); end
      @(negedge clk);
      rst = 1'b0;
      a_iv = 1'b0;
   endtask

   task automatic test_exhaustive_w1();
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vec;
         logic       exp_c;
         vec = 3'(v);
         @(negedge clk);
         a_i1 = vec[2]; a_i0 = vec[1]; a_s = vec[0]; a_iv = 1'b1;
         exp_c = vec[0] ? vec[2] : vec[1];
         #1;
         n_checks++; if (a_yc !== exp_c) begin n_fail++; $display("FAIL exh_ycomb v=%0d got=%0h exp=%0h", v, a_yc, exp_c); end
         clock_and_model();
         n_checks++; if (a_y !== exp_c || a_y !== e_ay) begin n_fail++; $display("FAIL exh_y v=%0d got=%0h exp=%0h", v, a_y, exp_c); end
         n_checks++; if (a_ov !== 1'b1 || a_sq !== vec[0]) begin n_fail++; $display("FAIL exh_ctl v=%0d got ov=%0h sq=%0h exp ov=1 sq=%0h", v, a_ov, a_sq, vec[0]); end
      end
      @(negedge clk);
      a_iv = 1'b0;
   endtask

   task automatic test_hold();
      @(negedge clk);
      b_i0 = 8'hA5; b_i1 = 8'hFF; b_s = SEL_I0; b_iv = 1'b1;
      clock_and_model();
      n_checks++; if (b_y !== 8'hA5) begin n_fail++; $display("FAIL hold_accept got=%0h exp=a5", b_y); end
      @(negedge clk);
      b_iv = 1'b0; b_i0 = 8'h3C;
      #1;
      n_checks++; if (b_yc !== 8'h3C) begin n_fail++; $display("FAIL hold_ycomb got=%0h exp=3c", b_yc); end
      n_checks++; if (b_y !== 8'hA5)  begin n_fail++; $display("FAIL hold_y_between_edges got=%0h exp=a5", b_y); end
      clock_and_model();
      n_checks++; if (b_y !== 8'hA5) begin n_fail++; $display("FAIL hold_y got=%0h exp=a5", b_y); end
      n_checks++; if (b_sq !== 1'b0) begin n_fail++; $display("FAIL hold_sel_q got=%0h exp=0", b_sq); end
      n_checks++; if (b_ov !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid got=%0h exp=0", b_ov); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h11; exp_seq[3] = 8'h22;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         b_i0 = 8'h11; b_i1 = 8'h22; b_s = k[0]; b_iv = 1'b1;
         clock_and_model();
         n_checks++; if (b_y !== exp_seq[k]) begin n_fail++; $display("FAIL stream_y k=%0d got=%0h exp=%0h", k, b_y, exp_seq[k]); end
         n_checks++; if (b_ov !== 1'b1) begin n_fail++; $display("FAIL stream_ov k=%0d got=%0h exp=1", k, b_ov); end
      end
      @(negedge clk);
      b_iv = 1'b0;
      clock_and_model();
      n_checks++; if (b_ov !== 1'b0) begin n_fail++; $display("FAIL stream_ov_drop got=%0h exp=0", b_ov); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         logic [7:0] exp_c;
         @(negedge clk);
         b_i0 = 8'($urandom); b_i1 = 8'($urandom);
         b_s  = 1'($urandom_range(1, 0)); b_iv = 1'($urandom_range(1, 0));
         a_i0 = 1'($urandom_range(1, 0)); a_i1 = 1'($urandom_range(1, 0));
         a_s  = 1'($urandom_range(1, 0)); a_iv = 1'($urandom_range(1, 0));
         exp_c = 8'(mux2(word_t'(b_i0), word_t'(b_i1), b_s));
         #1;
         n_checks++; if (b_yc !== exp_c) begin n_fail++; $display("FAIL rand_ycomb k=%0d got=%0h exp=%0h", k, b_yc, exp_c); end
         n_checks++; if (b_y !== e_by)   begin n_fail++; $display("FAIL rand_y_stable k=%0d got=%0h exp=%0h", k, b_y, e_by); end
         clock_and_model();
         n_checks++; if (b_y !== e_by || b_sq !== e_bsq || b_ov !== e_bov) begin
            n_fail++; $display("FAIL rand_b k=%0d got y=%0h sq=%0h ov=%0h exp y=%0h sq=%0h ov=%0h", k, b_y, b_sq, b_ov, e_by, e_bsq, e_bov);
         end
         n_checks++; if (a_y !== e_ay || a_sq !== e_asq || a_ov !== e_aov) begin
            n_fail++; $display("FAIL rand_a k=%0d got y=%0h sq=%0h ov=%0h exp y=%0h sq=%0h ov=%0h", k, a_y, a_sq, a_ov, e_ay, e_asq, e_aov);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive_w1();
      test_hold();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
